axil_arbiter_rr_rd: RTL
=======================

AXIL_ARBITER_RR_RD -- requirements
Module: axil_arbiter_rr_rd

Interface
REQ-001 SHALL have parameter NUMBER_MASTER, default 2, number of requesting masters; legal range 2..16.
REQ-002 SHALL have derived width CW = $clog2(NUMBER_MASTER), the width of the encoded grant.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic rises on its positive edge.
REQ-004 SHALL have port areset, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port request_rd, input, NUMBER_MASTER, per-master read request to this slave (arvalid qualified by the address decoder).
REQ-006 SHALL have port s_axil_arvalid, input, 1, slave-side AR valid as driven by the read crossbar.
REQ-007 SHALL have port s_axil_arready, input, 1, slave AR ready.
REQ-008 SHALL have port s_axil_rvalid, input, 1, slave R valid.
REQ-009 SHALL have port m_axil_rready, input, NUMBER_MASTER, per-master R ready.
REQ-010 SHALL have port grant_rd, output, NUMBER_MASTER, registered one-hot grant; all-zero when no grant.
REQ-011 SHALL have port grant_rd_cdr, output, CW, registered binary index of the granted master; 0 when no grant.
REQ-012 SHALL have port busy, output, 1, high while a read transaction owns this slave.

Function
REQ-013 SHALL implement an FSM with states IDLE, ADDR and DATA; only one read is outstanding per slave.
REQ-014 In IDLE with request_rd != 0, the FSM SHALL select the winner round-robin. The search starts at last_ptr+1 and wraps modulo NUMBER_MASTER. The FSM SHALL then go to ADDR.
REQ-015 grant_rd, grant_rd_cdr and busy SHALL update one cycle after the request is sampled in IDLE (latency 1).
REQ-016 In IDLE with request_rd == 0, the FSM SHALL stay in IDLE with all outputs zero.
REQ-017 In ADDR, the FSM SHALL go to DATA on the cycle s_axil_arvalid && s_axil_arready is high; otherwise it stays in ADDR.
REQ-018 In ADDR, s_axil_rvalid SHALL be ignored, including when it coincides with the AR handshake.
REQ-019 In DATA, the FSM SHALL go to IDLE on the cycle s_axil_rvalid && m_axil_rready[grant_rd_cdr] is high.
REQ-020 On that DATA-to-IDLE transition, last_ptr SHALL load grant_rd_cdr.
REQ-021 On the cycle after that transition, grant_rd and busy SHALL be 0.
REQ-022 rready from non-granted masters SHALL be ignored.
REQ-023 The grant SHALL be held unchanged through ADDR and DATA regardless of any change on request_rd, including withdrawal by the granted master.
REQ-024 A new arbitration SHALL occur no earlier than the cycle after the return to IDLE, giving a minimum of one idle cycle between grants.
REQ-025 grant_rd SHALL always be one-hot or zero, and grant_rd_cdr SHALL always match it.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 While areset is high at a clock edge, the block SHALL set: state to IDLE; grant_rd, grant_rd_cdr and busy to 0; last_ptr to NUMBER_MASTER-1 so that master 0 has top priority.
REQ-028 A reset asserted in ADDR or DATA SHALL abort the transaction with no other side effect; outputs are 0 on the next cycle.
REQ-029 Inputs SHALL be ignored while areset is high.

Verification
REQ-030 Reset: hold areset high for 2 cycles with request_rd all-ones -> grant_rd=0, grant_rd_cdr=0, busy=0 throughout; release -> grant_rd=0001 (N=4) one cycle later.
REQ-031 Single read (N=4): request_rd=0010 at cycle 0 -> grant_rd=0010, grant_rd_cdr=1, busy=1 at cycle 1; AR handshake at cycle 3 -> DATA; rvalid and m_axil_rready[1] at cycle 5 -> grant_rd=0, busy=0 at cycle 6.
REQ-032 Fairness (N=4): request_rd=1111 held, each read completing with immediate handshakes -> grant order 0,1,2,3,0,1; each grant's master wins exactly once per 4 transactions.
REQ-033 Grant hold: master 0 granted; request_rd changes to 0100 in ADDR -> grant_rd stays 0001 until master 0's R handshake; master 2 granted after the idle cycle.
REQ-034 Ignored handshakes:
  - s_axil_rvalid=1 in ADDR -> no state change.
  - In DATA, rvalid=1 with m_axil_rready[granted]=0 and other rready=1 for 10 cycles -> grant held for those 10 cycles.
REQ-035 Mid-transaction reset: areset pulsed in DATA with master 2 granted, then request_rd=0101 -> outputs 0 after reset; the next grant is master 0 because last_ptr was reset.

Source files
------------

// File: rtl/axil_arbiter_rr_rd_if.sv
// Read-arbitration signal bundle between the read crossbar and one slave's arbiter.
interface axil_arbiter_rr_rd_if #(
    parameter int unsigned NUMBER_MASTER = 2
);
    localparam int unsigned CW = $clog2(NUMBER_MASTER);

    logic [NUMBER_MASTER-1:0] request_rd;
    logic                     s_axil_arvalid;
    logic                     s_axil_arready;
    logic                     s_axil_rvalid;
    logic [NUMBER_MASTER-1:0] m_axil_rready;
    logic [NUMBER_MASTER-1:0] grant_rd;
    logic [CW-1:0]            grant_rd_cdr;
    logic                     busy;

    // Arbiter view: consumes requests and handshakes, produces the grant.
    modport slave (
        input  request_rd, s_axil_arvalid, s_axil_arready, s_axil_rvalid, m_axil_rready,
        output grant_rd, grant_rd_cdr, busy
    );

    // Crossbar view: drives requests and handshakes, observes the grant.
    modport master (
        output request_rd, s_axil_arvalid, s_axil_arready, s_axil_rvalid, m_axil_rready,
        input  grant_rd, grant_rd_cdr, busy
    );
endinterface

// File: rtl/axil_arbiter_rr_rd.sv
// Round-robin read arbiter for one AXI-Lite slave; one outstanding read at a time.
module axil_arbiter_rr_rd #(
    parameter int unsigned NUMBER_MASTER = 2
) (
    input  logic                 aclk,
    input  logic                 areset,
    axil_arbiter_rr_rd_if.slave  bus
);
    localparam int unsigned CW = $clog2(NUMBER_MASTER);
    localparam logic [NUMBER_MASTER-1:0] GRANT_ONE = NUMBER_MASTER'(1);
    localparam logic [CW-1:0] LAST_RESET = CW'(NUMBER_MASTER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [NUMBER_MASTER-1:0] grant_q, grant_d;
    logic [CW-1:0]            cdr_q, cdr_d;
    logic [CW-1:0]            last_q, last_d;
    logic                     busy_q, busy_d;

    logic                     rr_found_c;
    logic [CW-1:0]            rr_idx_c;
    int unsigned              rr_cand_c;

    // Round-robin search: first requester after last_q, wrapping modulo NUMBER_MASTER.
    always_comb begin
        rr_found_c = 1'b0;
        rr_idx_c   = '0;
        rr_cand_c  = 0;
        for (int unsigned k = 1; k <= NUMBER_MASTER; k++) begin
            rr_cand_c = 32'(last_q) + k;
            if (rr_cand_c >= NUMBER_MASTER) begin
                rr_cand_c = rr_cand_c - NUMBER_MASTER;
            end
            if (!rr_found_c && bus.request_rd[CW'(rr_cand_c)]) begin
                rr_found_c = 1'b1;
                rr_idx_c   = CW'(rr_cand_c);
            end
        end
    end

    // Next-state and next-output logic; the grant is frozen outside IDLE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cdr_d   = cdr_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                cdr_d   = '0;
                if (rr_found_c) begin
                    state_d = ADDR;
                    grant_d = GRANT_ONE << rr_idx_c;
                    cdr_d   = rr_idx_c;
                end
            end
            ADDR: begin
                // R channel activity is meaningless before the address is accepted.
                if (bus.s_axil_arvalid && bus.s_axil_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // Only the granted master's rready completes the read.
                if (bus.s_axil_rvalid && bus.m_axil_rready[cdr_q]) begin
                    state_d = IDLE;
                    last_d  = cdr_q;
                    grant_d = '0;
                    cdr_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cdr_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; synchronous reset gives master 0 top priority.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            grant_q <= '0;
            cdr_q   <= '0;
            last_q  <= LAST_RESET;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cdr_q   <= cdr_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant_rd     = grant_q;
    assign bus.grant_rd_cdr = cdr_q;
    assign bus.busy         = busy_q;

endmodule
